ndn_mcu_tx_scheduler: RTL and testbench

- Sits between the NDN router core and the SPI slave shifter that talks to the user MCU.
- Arbitrates round-robin between two packet sources (interest, data) and grants one per packet.
- Serialises the granted packet into the MCU framing as a byte stream with valid/ready:
  - interest: header byte + 8 prefix bytes;
  - data: header byte + 256 payload bytes, read from the data buffer.
- Raises an interrupt line so the MCU (SPI master) knows to clock a packet out.

---
 rtl/ndn_mcu_tx_scheduler_if.sv | 21 ++
 rtl/ndn_mcu_tx_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_ndn_mcu_tx_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ndn_mcu_tx_scheduler_if.sv
// Byte stream from the tx scheduler to the SPI slave shifter.
// The scheduler drives byte/valid as master; the shifter answers with ready.
interface ndn_mcu_tx_scheduler_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  // Scheduler side: presents bytes and waits for the shifter to take them.
  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  // Shifter side: observes bytes and signals acceptance.
  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ndn_mcu_tx_scheduler.sv
// NDN router -> MCU transmit scheduler.
// Picks one of two packet sources (interest / data) round-robin, frames the
// chosen packet as a byte stream for the SPI slave shifter and raises an
// interrupt so the MCU, acting as SPI master, knows a packet is waiting.
//   interest : header {0,1,len[5:0]} followed by PREFIX_BYTES prefix bytes,
//              most significant byte first
//   data     : header 8'h00 followed by DATA_BYTES bytes from the data buffer
// The data buffer has one cycle of read latency, so every payload byte costs
// a read cycle, a capture cycle and at least one send cycle.
// DATA_BYTES must not exceed 2**ADDR_W; the address counter stops on compare
// with the last address and never relies on wrapping.
module ndn_mcu_tx_scheduler #(
  parameter int PREFIX_BYTES = 8,
  parameter int DATA_BYTES   = 256,
  parameter int ADDR_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,

  // Interest source
  input  logic                      int_req,
  input  logic [5:0]                int_len,
  input  logic [8*PREFIX_BYTES-1:0] int_prefix,
  output logic                      int_ack,

  // Data source and its payload buffer read port
  input  logic                      dat_req,
  output logic                      dat_rd_en,
  output logic [ADDR_W-1:0]         dat_rd_addr,
  input  logic [7:0]                dat_rd_data,
  output logic                      dat_ack,

  // Byte stream to the SPI shifter
  ndn_mcu_tx_scheduler_if.master    tx,

  // Status towards the MCU
  output logic                      mcu_irq,
  output logic                      busy
);

  localparam int PW    = 8 * PREFIX_BYTES;
  localparam int IDX_W = (PREFIX_BYTES > 1) ? $clog2(PREFIX_BYTES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PREFIX_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PREFIX,
    DRD,
    DWAIT,
    DSEND,
    DONE
  } state_t;

  typedef enum logic {
    SRC_INT,
    SRC_DAT
  } src_t;

  state_t            state_q;
  src_t              src_q;
  src_t              lastGrant_q;
  logic [PW-1:0]     prefix_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        txByte_q;
  logic              txValid_q;
  logic              rdEn_q;
  logic              intAck_q;
  logic              datAck_q;
  logic              irq_q;
  logic              busy_q;

  logic              txHs;
  logic              grantInt;
  logic              grantDat;

  // A byte moves only when it is actually offered; ready alone means nothing.
  always_comb begin
    txHs = txValid_q && tx.tx_ready;
  end

  // Round-robin choice: a lone request wins outright, a tie goes to the
  // source that was not served last time.
  always_comb begin
    grantInt = 1'b0;
    grantDat = 1'b0;
    if (int_req && (!dat_req || (lastGrant_q == SRC_DAT))) begin
      grantInt = 1'b1;
    end else if (dat_req) begin
      grantDat = 1'b1;
    end
  end

  // Packet sequencer with all outputs registered. Acks and the buffer read
  // strobe are single-cycle pulses, so they default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_INT;
      lastGrant_q <= SRC_DAT;
      prefix_q    <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      txByte_q    <= '0;
      txValid_q   <= 1'b0;
      rdEn_q      <= 1'b0;
      intAck_q    <= 1'b0;
      datAck_q    <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rdEn_q   <= 1'b0;
      intAck_q <= 1'b0;
      datAck_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grantInt) begin
            src_q       <= SRC_INT;
            lastGrant_q <= SRC_INT;
            prefix_q    <= int_prefix;
            txByte_q    <= {2'b01, int_len};
            txValid_q   <= 1'b1;
            irq_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= HDR;
          end else if (grantDat) begin
            src_q       <= SRC_DAT;
            lastGrant_q <= SRC_DAT;
            txByte_q    <= 8'h00;
            txValid_q   <= 1'b1;
            irq_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= HDR;
          end
        end

        HDR: begin
          if (txHs) begin
            irq_q <= 1'b0;
            if (src_q == SRC_INT) begin
              txByte_q <= prefix_q[PW-1 -: 8];
              prefix_q <= prefix_q << 8;
              idx_q    <= '0;
              state_q  <= PREFIX;
            end else begin
              txValid_q <= 1'b0;
              addr_q    <= '0;
              rdEn_q    <= 1'b1;
              state_q   <= DRD;
            end
          end
        end

        PREFIX: begin
          if (txHs) begin
            if (idx_q == LAST_IDX) begin
              txValid_q <= 1'b0;
              intAck_q  <= 1'b1;
              state_q   <= DONE;
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              txByte_q <= prefix_q[PW-1 -: 8];
              prefix_q <= prefix_q << 8;
            end
          end
        end

        DRD: begin
          state_q <= DWAIT;
        end

        DWAIT: begin
          txByte_q  <= dat_rd_data;
          txValid_q <= 1'b1;
          state_q   <= DSEND;
        end

        DSEND: begin
          if (txHs) begin
            txValid_q <= 1'b0;
            if (addr_q == LAST_ADDR) begin
              datAck_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              rdEn_q  <= 1'b1;
              state_q <= DRD;
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          txValid_q <= 1'b0;
          irq_q     <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign tx.tx_byte  = txByte_q;
  assign tx.tx_valid = txValid_q;

  assign dat_rd_en   = rdEn_q;
  assign dat_rd_addr = addr_q;
  assign int_ack     = intAck_q;
  assign dat_ack     = datAck_q;
  assign mcu_irq     = irq_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ndn_mcu_tx_scheduler.sv
// Self-checking bench for ndn_mcu_tx_scheduler.
// Expected byte streams and grant order come from a packet-level model:
// a packet is a list of bytes, and the order of packets follows the
// round-robin rule applied to whole packets.
module tb_ndn_mcu_tx_scheduler;

  localparam int PREFIX_BYTES = 8;
  localparam int DATA_BYTES   = 256;
  localparam int ADDR_W       = 8;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      int_req = 1'b0;
  logic [5:0]                int_len = '0;
  logic [8*PREFIX_BYTES-1:0] int_prefix = '0;
  logic                      int_ack;
  logic                      dat_req = 1'b0;
  logic                      dat_rd_en;
  logic [ADDR_W-1:0]         dat_rd_addr;
  logic [7:0]                dat_rd_data = '0;
  logic                      dat_ack;
  logic                      mcu_irq;
  logic                      busy;

  ndn_mcu_tx_scheduler_if txIf();

  ndn_mcu_tx_scheduler #(
    .PREFIX_BYTES(PREFIX_BYTES),
    .DATA_BYTES  (DATA_BYTES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_req    (int_req),
    .int_len    (int_len),
    .int_prefix (int_prefix),
    .int_ack    (int_ack),
    .dat_req    (dat_req),
    .dat_rd_en  (dat_rd_en),
    .dat_rd_addr(dat_rd_addr),
    .dat_rd_data(dat_rd_data),
    .dat_ack    (dat_ack),
    .tx         (txIf),
    .mcu_irq    (mcu_irq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Data buffer with one cycle of read latency.
  logic [7:0] bufMem [DATA_BYTES];
  always @(posedge clk) begin
    if (dat_rd_en) dat_rd_data <= bufMem[dat_rd_addr];
  end

  typedef struct {
    logic [5:0]  len;
    logic [63:0] prefix;
    logic [7:0]  expHdr;
    logic [7:0]  expFirst;
    logic [7:0]  expLast;
  } vec_t;

  int         checks = 0;
  int         passed = 0;
  logic [7:0] rxQ [$];
  int         ackOrder [$];
  int         intAckCnt = 0;
  int         datAckCnt = 0;
  int         cycleCnt = 0;
  int         lastHsCycle = 0;
  int         pktByteIdx = 0;
  bit         prevStall = 0;
  logic [7:0] prevByte = '0;
  bit         prevHdrHs = 0;
  bit         randomReady = 0;
  logic [7:0] stallByte = '0;
  int         stallLeft = 0;
  bit         sawRd = 0;
  int         firstRdAddr = -1;
  int         maxRdAddr = -1;
  int         lastGrant = 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [63:0] getRx(input int i);
    if (i < rxQ.size()) return {56'h0, rxQ[i]};
    return 64'hBAD;
  endfunction

  function automatic int encodeOrder(input int q[$]);
    int e = 0;
    foreach (q[i]) e = e | ((q[i] + 1) << (2 * i));
    return e;
  endfunction

  // One clock of observation: ready is chosen first, then the handshake that
  // the next rising edge will perform is recorded.
  task automatic stepCycle();
    @(negedge clk);
    cycleCnt++;
    if (prevStall) begin
      checkOutput("hold_valid", txIf.tx_valid, 1);
      checkOutput("hold_byte", txIf.tx_byte, prevByte);
    end
    if (prevHdrHs) checkOutput("irq_clear", mcu_irq, 0);
    prevHdrHs = 0;
    if (int_ack) begin
      intAckCnt++;
      ackOrder.push_back(0);
      checkOutput("int_ack_latency", cycleCnt - lastHsCycle, 1);
      checkOutput("int_ack_busy_valid", {busy, txIf.tx_valid}, 2'b10);
      int_req = 1'b0;
      pktByteIdx = 0;
    end
    if (dat_ack) begin
      datAckCnt++;
      ackOrder.push_back(1);
      checkOutput("dat_ack_latency", cycleCnt - lastHsCycle, 1);
      checkOutput("dat_ack_busy_valid", {busy, txIf.tx_valid}, 2'b10);
      dat_req = 1'b0;
      pktByteIdx = 0;
    end
    if (txIf.tx_valid && stallLeft > 0 && txIf.tx_byte == stallByte) begin
      txIf.tx_ready = 1'b0;
      stallLeft--;
    end else if (randomReady) begin
      txIf.tx_ready = ($urandom_range(0, 3) != 0);
    end else begin
      txIf.tx_ready = 1'b1;
    end
    if (txIf.tx_valid && pktByteIdx == 0) checkOutput("irq_busy_at_hdr", {mcu_irq, busy}, 2'b11);
    if (dat_rd_en) begin
      if (!sawRd) firstRdAddr = int'(dat_rd_addr);
      sawRd = 1;
      if (int'(dat_rd_addr) > maxRdAddr) maxRdAddr = int'(dat_rd_addr);
    end
    if (txIf.tx_valid && txIf.tx_ready) begin
      rxQ.push_back(txIf.tx_byte);
      lastHsCycle = cycleCnt;
      if (pktByteIdx == 0) prevHdrHs = 1;
      pktByteIdx++;
    end
    prevStall = txIf.tx_valid && !txIf.tx_ready;
    prevByte  = txIf.tx_byte;
  endtask

  // Raise the requested sources together from idle and check the packets
  // that come out against the packet-level model.
  task automatic applyStimulus(input string tag, input bit wantI, input bit wantD,
                               input logic [5:0] len, input logic [63:0] prefix);
    logic [7:0] exp [$];
    int order [$];
    int cycles = 0;
    int mis = -1;
    int nI = 0;
    int nD = 0;
    rxQ.delete();
    ackOrder.delete();
    intAckCnt = 0;
    datAckCnt = 0;
    sawRd = 0;
    firstRdAddr = -1;
    maxRdAddr = -1;
    if (wantI && wantD) begin
      if (lastGrant == 1) order = '{0, 1};
      else order = '{1, 0};
    end else if (wantI) order = '{0};
    else order = '{1};
    foreach (order[k]) begin
      if (order[k] == 0) begin
        nI++;
        exp.push_back({2'b01, len});
        for (int b = 0; b < PREFIX_BYTES; b++)
          exp.push_back(8'(prefix >> (8 * (PREFIX_BYTES - 1 - b))));
      end else begin
        nD++;
        exp.push_back(8'h00);
        for (int a = 0; a < DATA_BYTES; a++) exp.push_back(bufMem[a]);
      end
      lastGrant = order[k];
    end
    int_len    = len;
    int_prefix = prefix;
    int_req    = wantI;
    dat_req    = wantD;
    while (ackOrder.size() < order.size() && cycles < 20000) begin
      stepCycle();
      cycles++;
    end
    checkOutput({tag, "_completed"}, ackOrder.size(), order.size());
    repeat (3) stepCycle();
    checkOutput({tag, "_count"}, rxQ.size(), exp.size());
    for (int i = 0; i < rxQ.size() && i < exp.size(); i++)
      if (mis < 0 && rxQ[i] !== exp[i]) mis = i;
    checkOutput($sformatf("%s_byte%0d", tag, (mis < 0) ? 0 : mis),
                (mis < 0) ? 64'h0 : {56'h0, rxQ[mis]},
                (mis < 0) ? 64'h0 : {56'h0, exp[mis]});
    checkOutput({tag, "_order"}, encodeOrder(ackOrder), encodeOrder(order));
    checkOutput({tag, "_int_acks"}, intAckCnt, nI);
    checkOutput({tag, "_dat_acks"}, datAckCnt, nD);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {txIf.tx_valid, txIf.tx_byte, mcu_irq, busy, int_ack, dat_ack, dat_rd_en, dat_rd_addr}, 0);
  endtask

  vec_t vecs [4];

  initial begin
    int cycles;
    int sel;

    vecs[0] = '{6'h15, 64'h0102030405060708, 8'h55, 8'h01, 8'h08};
    vecs[1] = '{6'h00, 64'hFFEEDDCCBBAA9988, 8'h40, 8'hFF, 8'h88};
    vecs[2] = '{6'h3F, 64'h8000000000000001, 8'h7F, 8'h80, 8'h01};
    vecs[3] = '{6'h2A, 64'hDEADBEEFCAFEF00D, 8'h6A, 8'hDE, 8'h0D};

    for (int a = 0; a < DATA_BYTES; a++) bufMem[a] = 8'(a) ^ 8'hA5;
    txIf.tx_ready = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset_outputs");
    rst_n = 1'b1;
    stepCycle();
    checkAllZero("idle_after_reset");

    // Tie from reset: interest first, then data, and again on re-assertion.
    applyStimulus("both1", 1, 1, 6'h15, 64'h0102030405060708);
    applyStimulus("both2", 1, 1, 6'h2A, 64'h1122334455667788);

    // Interest-only table.
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("intv%0d", i), 1, 0, vecs[i].len, vecs[i].prefix);
      checkOutput($sformatf("intv%0d_hdr", i), getRx(0), {56'h0, vecs[i].expHdr});
      checkOutput($sformatf("intv%0d_first", i), getRx(1), {56'h0, vecs[i].expFirst});
      checkOutput($sformatf("intv%0d_last", i), getRx(8), {56'h0, vecs[i].expLast});
    end

    // Data only with a known buffer pattern.
    applyStimulus("data", 0, 1, 6'h00, 64'h0);
    checkOutput("data_payload0", getRx(1), 64'hA5);
    checkOutput("data_payload255", getRx(256), 64'h5A);
    checkOutput("data_first_addr", firstRdAddr, 0);
    checkOutput("data_max_addr", maxRdAddr, 255);

    // Backpressure on prefix byte 3.
    stallByte = 8'h03;
    stallLeft = 5;
    applyStimulus("bp", 1, 0, 6'h15, 64'h0102030405060708);
    checkOutput("bp_stalls_used", stallLeft, 0);

    // Header held off for 10 cycles: interrupt must stay up until accepted.
    stallByte = 8'h55;
    stallLeft = 10;
    applyStimulus("irq", 1, 0, 6'h15, 64'h0A0B0C0D0E0F1011);
    checkOutput("irq_stalls_used", stallLeft, 0);

    // Randomized request mixes, contents and ready.
    randomReady = 1;
    for (int r = 0; r < 10; r++) begin
      sel = $urandom_range(1, 3);
      for (int a = 0; a < DATA_BYTES; a++) bufMem[a] = 8'($urandom);
      applyStimulus($sformatf("rnd%0d", r), sel[0], sel[1], 6'($urandom), {$urandom, $urandom});
    end
    randomReady = 0;

    // Reset in the middle of a data packet, then restart from the header.
    for (int a = 0; a < DATA_BYTES; a++) bufMem[a] = 8'(a) ^ 8'hA5;
    rxQ.delete();
    datAckCnt = 0;
    dat_req = 1'b1;
    cycles = 0;
    while (rxQ.size() < 101 && cycles < 2000) begin
      stepCycle();
      cycles++;
    end
    checkOutput("midrst_reached", rxQ.size(), 101);
    checkOutput("midrst_no_ack_before", datAckCnt, 0);
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst_outputs");
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_ack", {dat_ack, busy}, 0);
    end
    rst_n = 1'b1;
    prevStall  = 0;
    prevHdrHs  = 0;
    pktByteIdx = 0;
    lastGrant  = 1;
    applyStimulus("restart", 0, 1, 6'h00, 64'h0);
    checkOutput("restart_hdr", getRx(0), 64'h00);
    checkOutput("restart_first_addr", firstRdAddr, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
